// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial multi-cycle adder/subtractor built from one registered full-adder slice
//
// Purpose: adds or subtracts two WIDTH-bit operands one bit per clock, LSB first,
// reusing a single full-adder slice. Operands are captured on start_in while idle;
// the result appears WIDTH cycles later together with a one-cycle done_out pulse.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   start_in     begin an operation (accepted only while ready_out=1)
//   sub_in       0 = add, 1 = subtract (sampled with start_in)
//   a_in, b_in   operands (sampled with start_in)
//   c_in         carry-in (add) / borrow-in (subtract)
//   ready_out    idle and able to accept start_in
//   busy_out     bits are being processed
//   done_out     one-cycle pulse when the result becomes valid
//   sum_out      result
//   carry_out    carry out of the MSB (subtract: 1 = no borrow)
//   overflow_out two's-complement signed overflow

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_in,
  input  logic             sub_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             ready_out,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_co;
  logic             last_bit;

  // The single full-adder slice shared by every bit position.
  assign fa_sum   = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_co    = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign last_bit = (cnt == LAST_BIT);

  // Sum bits enter from the MSB side so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = fa_sum;
    end else begin : g_res_wn
      assign res_next = {fa_sum, res_sh[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_in) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      a_sh         <= '0;
      b_sh         <= '0;
      res_sh       <= '0;
      cnt          <= '0;
      carry        <= 1'b0;
      sum_out      <= '0;
      carry_out    <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start_in) begin
            a_sh  <= a_in;
            // Subtraction is a + ~b + ~borrow_in.
            b_sh  <= sub_in ? ~b_in : b_in;
            carry <= sub_in ^ c_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_co;
          res_sh <= res_next;
          if (last_bit) begin
            cnt          <= '0;
            sum_out      <= res_next;
            carry_out    <= fa_co;
            // carry holds the carry into the MSB on this edge.
            overflow_out <= carry ^ fa_co;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_out = (state == IDLE);
  assign busy_out  = (state == RUN);
  assign done_out  = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances)

module tb_serial_adder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       start8, sub8, c8;
  logic [7:0] a8, b8;
  logic       ready8, busy8, done8, carry8, ovf8;
  logic [7:0] sum8;

  logic       start1, sub1, c1;
  logic [0:0] a1, b1;
  logic       ready1, busy1, done1, carry1, ovf1;
  logic [0:0] sum1;

  int vectors = 0;
  int miscompares = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start_in(start8), .sub_in(sub8),
    .a_in(a8), .b_in(b8), .c_in(c8),
    .ready_out(ready8), .busy_out(busy8), .done_out(done8),
    .sum_out(sum8), .carry_out(carry8), .overflow_out(ovf8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clock(clock), .reset(reset), .start_in(start1), .sub_in(sub1),
    .a_in(a1), .b_in(b1), .c_in(c1),
    .ready_out(ready1), .busy_out(busy1), .done_out(done1),
    .sum_out(sum1), .carry_out(carry1), .overflow_out(ovf1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  // Returns {overflow, carry, sum[7:0]}.
  function automatic logic [9:0] model(input int w, input int a, input int b,
                                       input bit sub, input bit cin);
    int m, sa, sb, t, s, sum;
    bit carry, ovf;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (!sub) begin
      t     = a + b + int'(cin);
      carry = (t >= m);
      sum   = t % m;
      s     = sa + sb + int'(cin);
    end else begin
      t     = a - b - int'(cin);
      carry = (t >= 0);
      sum   = (t + 2 * m) % m;
      s     = sa - sb - int'(cin);
    end
    ovf = (s >= m / 2) || (s < -(m / 2));
    return {ovf, carry, sum[7:0]};
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                     input logic cin, input bit disturb);
    logic [9:0] e;
    int n;
    e = model(8, int'(a), int'(b), sub, cin);
    @(negedge clock);
    chk("ready8_before_start", ready8, 1);
    a8 = a; b8 = b; sub8 = sub; c8 = cin; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    chk("busy8_after_accept", {busy8, ready8}, 2'b10);
    n = 0;
    while (!done8 && n < 40) begin
      @(negedge clock);
      if (disturb) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
        sub8 = 1'($urandom); c8 = 1'($urandom); start8 = 1'b1;
      end
      @(posedge clock); #1;
      n++;
    end
    start8 = 1'b0;
    chk("latency8", 64'(n), 64'd8);
    chk("sum8", sum8, e[7:0]);
    chk("carry8", carry8, e[8]);
    chk("ovf8", ovf8, e[9]);
    chk("flags8_in_done", {busy8, ready8}, 2'b00);
    @(posedge clock); #1;
    chk("done8_one_cycle", {done8, ready8}, 2'b01);
  endtask

  task automatic op1(input logic a, input logic b, input logic sub, input logic cin);
    logic [9:0] e;
    int n;
    e = model(1, int'(a), int'(b), sub, cin);
    @(negedge clock);
    a1 = a; b1 = b; sub1 = sub; c1 = cin; start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    chk("latency1", 64'(n), 64'd1);
    chk("result1", {ovf1, carry1, sum1}, {e[9], e[8], e[0]});
    @(posedge clock); #1;
    chk("done1_one_cycle", {done1, ready1}, 2'b01);
  endtask

  initial begin
    reset = 1'b1;
    start8 = 0; sub8 = 0; c8 = 0; a8 = 0; b8 = 0;
    start1 = 0; sub1 = 0; c1 = 0; a1 = 0; b1 = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset8_state", {ready8, busy8, done8, sum8, carry8, ovf8}, {3'b100, 8'h00, 2'b00});
    chk("reset1_state", {ready1, busy1, done1, sum1, carry1, ovf1}, 6'b100000);
    @(negedge clock);
    reset = 1'b0;

    // Directed cases with literal expectations.
    op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("t1_literal", {ovf8, carry8, sum8}, {2'b10, 8'h96});
    op8(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
    chk("t2_literal", {ovf8, carry8, sum8}, {2'b01, 8'h01});
    op8(8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
    chk("t3_literal", {ovf8, carry8, sum8}, {2'b00, 8'hF0});
    op8(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
    chk("t4_literal", {ovf8, carry8, sum8}, {2'b11, 8'h7F});

    // start_in and operand changes during RUN must be ignored.
    op8(8'h33, 8'h44, 1'b0, 1'b0, 1'b1);
    chk("t5_literal", {ovf8, carry8, sum8}, {2'b00, 8'h77});

    // Reset when bit 4 is about to be processed.
    @(negedge clock);
    a8 = 8'h12; b8 = 8'h34; sub8 = 0; c8 = 0; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_state", {ready8, busy8, done8, sum8, carry8, ovf8}, {3'b100, 8'h00, 2'b00});
    begin
      bit saw_done = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clock); #1;
        if (done8) saw_done = 1;
      end
      chk("abort_no_done", saw_done, 0);
    end
    op8(8'hC8, 8'h64, 1'b0, 1'b1, 1'b0);

    // Reset and start on the same edge: reset wins.
    @(negedge clock);
    reset = 1'b1; start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    @(posedge clock); #1;
    reset = 1'b0; start8 = 1'b0;
    chk("reset_beats_start", {ready8, busy8, sum8}, {2'b10, 8'h00});

    // Randomised operations against the reference model.
    for (int i = 0; i < 30; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), (i % 5) == 0);
    op8(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    op8(8'h7F, 8'h7F, 1'b0, 1'b1, 1'b0);

    // WIDTH=1 instance: all input combinations.
    op1(1'b1, 1'b1, 1'b0, 1'b1);
    chk("w1_literal", {ovf1, carry1, sum1}, 3'b011);
    for (int i = 0; i < 16; i++)
      op1(i[0], i[1], i[2], i[3]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
